// File: rtl/selftest_monitor.sv
// selftest_monitor: self-test checkpoint monitor.
// Snoops the core register-file write port and matches writes against NUM_CH
// programmed (register, value) checkpoints. A cycle timeout bounds the run.
// Status is reported on checkbits: [15:12] state code, [11:8] first failing
// channel, [7:0] hit mask (zero-extended).
// Optional feature macro: SELFTEST_TIMESTAMP_EN adds per-channel hit
// timestamps readable through ts_sel / ts_value.
//
// Control interface: start and abort are single-cycle pulses sampled on the
// rising clock edge. cfg_we / cfg_timeout_we are single-cycle write strobes
// that only land while the monitor sits in IDLE. There is no back-pressure.
module selftest_monitor #(
  parameter int NUM_CH          = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5,
  parameter int TIMEOUT_W       = 24,
  parameter int DEFAULT_TIMEOUT = 100000,
  parameter int IN_ORDER        = 0
) (
  input  logic                 clock,
  input  logic                 resetb,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_ch,
  input  logic                 cfg_en,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic                 cfg_timeout_we,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 rf_we,
  input  logic [ADDR_W-1:0]    rf_waddr,
  input  logic [DATA_W-1:0]    rf_wdata,
  output logic [15:0]          checkbits,
  output logic [NUM_CH-1:0]    hit_mask,
  output logic [TIMEOUT_W-1:0] cycles,
`ifdef SELFTEST_TIMESTAMP_EN
  input  logic [2:0]           ts_sel,
  output logic [TIMEOUT_W-1:0] ts_value,
`endif
  output logic                 done
);

  // State encoding doubles as the code shown on checkbits[15:12].
  typedef enum logic [3:0] {
    S_IDLE    = 4'h0,
    S_RUN     = 4'h1,
    S_PASS    = 4'hA,
    S_TIMEOUT = 4'hE,
    S_FAIL    = 4'hF
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    ch_en_q;
  logic [ADDR_W-1:0]    ch_addr_q  [NUM_CH];
  logic [DATA_W-1:0]    ch_value_q [NUM_CH];
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [NUM_CH-1:0]    hit_q, hit_d;
  logic [TIMEOUT_W-1:0] cycles_q, cycles_d;
  logic [3:0]           fail_idx_q, fail_idx_d;

  logic                 cfg_open;
  logic [NUM_CH-1:0]    match, pending, expect_oh, good, bad;
  logic [3:0]           bad_idx;
  logic                 complete;
  logic                 tmo_hit;
  logic [TIMEOUT_W-1:0] cycles_inc;
  logic [7:0]           hit_ext;
  logic [3:0]           state_code;

  // Configuration is only writable while idle; an abort on the same edge wins.
  assign cfg_open = (state_q == S_IDLE) && !abort;

  // Raw per-channel match of the current register-file write; x0 never matches.
  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      match[k] = rf_we && (rf_waddr != '0) && ch_en_q[k] && !hit_q[k] &&
                 (rf_waddr == ch_addr_q[k]) && (rf_wdata == ch_value_q[k]);
    end
  end

  // Lowest-index enabled channel still waiting for its hit.
  assign pending   = ch_en_q & ~hit_q;
  assign expect_oh = pending & (~pending + NUM_CH'(1));

  // Split matches into accepted hits and ordering violations.
  always_comb begin
    if (IN_ORDER != 0) begin
      good = match & expect_oh;
      bad  = match & ~expect_oh;
    end else begin
      good = match;
      bad  = '0;
    end
    bad_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (bad[k]) bad_idx = 4'(k);
    end
  end

  assign complete   = ((hit_q | good) & ch_en_q) == ch_en_q;
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + TIMEOUT_W'(1);
  assign tmo_hit    = (timeout_q != '0) && (cycles_q == timeout_q - TIMEOUT_W'(1));

  // Next-state and next-status logic; FAIL beats PASS, PASS beats TIMEOUT.
  always_comb begin
    state_d    = state_q;
    hit_d      = hit_q;
    cycles_d   = cycles_q;
    fail_idx_d = fail_idx_q;
    if (abort) begin
      state_d    = S_IDLE;
      hit_d      = '0;
      cycles_d   = '0;
      fail_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_RUN;
            hit_d      = '0;
            cycles_d   = '0;
            fail_idx_d = '0;
          end
        end
        S_RUN: begin
          cycles_d = cycles_inc;
          if (bad != '0) begin
            state_d    = S_FAIL;
            fail_idx_d = bad_idx;
          end else begin
            hit_d = hit_q | good;
            if (complete)     state_d = S_PASS;
            else if (tmo_hit) state_d = S_TIMEOUT;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Status registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      hit_q      <= '0;
      cycles_q   <= '0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      cycles_q   <= cycles_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Checkpoint and timeout configuration registers; channel indices past NUM_CH are dropped.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ch_en_q   <= '0;
      timeout_q <= TIMEOUT_W'(DEFAULT_TIMEOUT);
      for (int k = 0; k < NUM_CH; k++) begin
        ch_addr_q[k]  <= '0;
        ch_value_q[k] <= '0;
      end
    end else if (cfg_open) begin
      if (cfg_we) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (cfg_ch == 3'(k)) begin
            ch_en_q[k]    <= cfg_en;
            ch_addr_q[k]  <= cfg_addr;
            ch_value_q[k] <= cfg_data;
          end
        end
      end
      if (cfg_timeout_we) timeout_q <= cfg_timeout;
    end
  end

`ifdef SELFTEST_TIMESTAMP_EN
  logic [TIMEOUT_W-1:0] ts_q [NUM_CH];
  logic                 ts_clear;
  logic                 hit_apply;

  assign ts_clear  = abort || ((state_q == S_IDLE) && start);
  assign hit_apply = (state_q == S_RUN) && !abort && (bad == '0);

  // Capture the post-edge cycle count on each channel's hit edge.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < NUM_CH; k++) ts_q[k] <= '0;
    end else if (ts_clear) begin
      for (int k = 0; k < NUM_CH; k++) ts_q[k] <= '0;
    end else if (hit_apply) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (good[k]) ts_q[k] <= cycles_inc;
      end
    end
  end

  // Timestamp read mux; out-of-range selects read as zero.
  always_comb begin
    ts_value = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ts_sel == 3'(k)) ts_value = ts_q[k];
    end
  end
`endif

  assign state_code = state_q;
  assign hit_ext    = 8'(hit_q);
  assign checkbits  = {state_code, fail_idx_q, hit_ext};
  assign hit_mask   = hit_q;
  assign cycles     = cycles_q;
  assign done       = (state_q == S_PASS) || (state_q == S_FAIL) || (state_q == S_TIMEOUT);

endmodule
